// File: rtl/branch_stack_if.sv
// Dispatch / branch-FU side bundle of the branch checkpoint tracker.
// The res_task encoding is 0 = NOTHING, 1 = CLEAR, 2 = SQUASH.
interface branch_stack_if #(
  parameter int DEPTH  = 4,
  parameter int CKPT_W = 64
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // allocation (dispatch)
  logic                alloc_req;
  logic [CKPT_W-1:0]   alloc_ckpt;
  logic                alloc_gnt;
  logic [DEPTH-1:0]    alloc_b_id;
  logic [DEPTH-1:0]    alloc_b_mask;
  logic                full;
  // resolve (branch FU)
  logic                res_valid;
  logic [1:0]          res_task;
  logic [DEPTH-1:0]    res_b_id;
  logic [31:0]         res_target;
  // broadcasts
  logic                clear_valid;
  logic [DEPTH-1:0]    clear_b_id;
  logic                squash_valid;
  logic [DEPTH-1:0]    squash_b_mask;
  logic [CKPT_W-1:0]   squash_ckpt;
  logic [31:0]         squash_target;
  logic [CNT_W-1:0]    live_cnt;

  modport master (
    output alloc_req, alloc_ckpt, res_valid, res_task, res_b_id, res_target,
    input  alloc_gnt, alloc_b_id, alloc_b_mask, full,
           clear_valid, clear_b_id, squash_valid, squash_b_mask,
           squash_ckpt, squash_target, live_cnt
  );

  modport slave (
    input  alloc_req, alloc_ckpt, res_valid, res_task, res_b_id, res_target,
    output alloc_gnt, alloc_b_id, alloc_b_mask, full,
           clear_valid, clear_b_id, squash_valid, squash_b_mask,
           squash_ckpt, squash_target, live_cnt
  );
endinterface

// File: rtl/branch_stack.sv
// Branch checkpoint tracker: hands out one-hot branch ids with dependency
// masks, stores recovery payloads, and turns FU resolves into one-cycle
// clear / squash broadcasts.
module branch_stack #(
  parameter int DEPTH  = 4,
  parameter int CKPT_W = 64
) (
  input logic          clock,
  input logic          reset,
  branch_stack_if.slave bus
);
  localparam int         CNT_W    = $clog2(DEPTH + 1);
  localparam logic [1:0] T_CLEAR  = 2'd1;
  localparam logic [1:0] T_SQUASH = 2'd2;

  logic [DEPTH-1:0]             valid, valid_n;
  logic [DEPTH-1:0][DEPTH-1:0]  dep, dep_n;
  logic [DEPTH-1:0][CKPT_W-1:0] ckpt, ckpt_n;
  logic [CNT_W-1:0]             live_cnt, live_n;

  logic                clear_valid, squash_valid;
  logic [DEPTH-1:0]    clear_b_id, squash_b_mask;
  logic [CKPT_W-1:0]   squash_ckpt;
  logic [31:0]         squash_target;

  logic                hit, do_clear, do_squash, squash_req, full, gnt;
  logic [DEPTH-1:0]    clr_bit, lowest_free, grant, alloc_mask, kill;
  logic [CKPT_W-1:0]   sel_ckpt;

  // A resolve only counts when it names a live entry.
  assign hit        = bus.res_valid & (|(valid & bus.res_b_id));
  assign do_clear   = hit & (bus.res_task == T_CLEAR);
  assign do_squash  = hit & (bus.res_task == T_SQUASH);
  // Allocation is held off by any squash request, live target or not.
  assign squash_req = bus.res_valid & (bus.res_task == T_SQUASH);
  assign clr_bit    = do_clear ? bus.res_b_id : '0;

  // Full and the free slot come from the pre-edge valid vector, so a slot
  // freed by a same-cycle clear is only reusable next cycle.
  assign full        = &valid;
  assign lowest_free = ~valid & (valid + DEPTH'(1));
  assign gnt         = bus.alloc_req & ~full & ~squash_req;
  assign grant       = gnt ? lowest_free : '0;
  assign alloc_mask  = valid & ~clr_bit;

  assign bus.alloc_gnt     = gnt;
  assign bus.alloc_b_id    = grant;
  assign bus.alloc_b_mask  = alloc_mask;
  assign bus.full          = full;
  assign bus.clear_valid   = clear_valid;
  assign bus.clear_b_id    = clear_b_id;
  assign bus.squash_valid  = squash_valid;
  assign bus.squash_b_mask = squash_b_mask;
  assign bus.squash_ckpt   = squash_ckpt;
  assign bus.squash_target = squash_target;
  assign bus.live_cnt      = live_cnt;

  // Kill set = resolving branch plus every live entry depending on it;
  // also mux out the resolving entry's payload.
  always_comb begin
    kill     = bus.res_b_id;
    sel_ckpt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (valid[j] && |(dep[j] & bus.res_b_id)) kill[j] = 1'b1;
      if (bus.res_b_id[j]) sel_ckpt |= ckpt[j];
    end
  end

  // Next table state: clear/squash first, then the new allocation.
  always_comb begin
    valid_n = valid;
    dep_n   = dep;
    ckpt_n  = ckpt;
    live_n  = '0;
    if (do_clear) begin
      valid_n &= ~clr_bit;
      for (int i = 0; i < DEPTH; i++) dep_n[i] &= ~clr_bit;
    end
    if (do_squash) begin
      valid_n &= ~kill;
      for (int i = 0; i < DEPTH; i++) if (kill[i]) dep_n[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        valid_n[i] = 1'b1;
        dep_n[i]   = alloc_mask;
        ckpt_n[i]  = bus.alloc_ckpt;
      end
    end
    for (int i = 0; i < DEPTH; i++) live_n += CNT_W'(valid_n[i]);
  end

  // Table state and one-cycle broadcast pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid         <= '0;
      dep           <= '0;
      ckpt          <= '0;
      live_cnt      <= '0;
      clear_valid   <= 1'b0;
      clear_b_id    <= '0;
      squash_valid  <= 1'b0;
      squash_b_mask <= '0;
      squash_ckpt   <= '0;
      squash_target <= '0;
    end else begin
      valid         <= valid_n;
      dep           <= dep_n;
      ckpt          <= ckpt_n;
      live_cnt      <= live_n;
      clear_valid   <= do_clear;
      clear_b_id    <= do_clear ? bus.res_b_id : '0;
      squash_valid  <= do_squash;
      squash_b_mask <= do_squash ? kill : '0;
      squash_ckpt   <= do_squash ? sel_ckpt : '0;
      squash_target <= do_squash ? bus.res_target : '0;
    end
  end
endmodule

// File: tb/tb_branch_stack.sv
// Self-checking bench for branch_stack: directed scenarios plus a random run
// against an age-ordered reference model.
module tb_branch_stack;
  localparam int         D   = 4;
  localparam int         W   = 64;
  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] CLR = 2'd1;
  localparam logic [1:0] SQ  = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  branch_stack_if #(.DEPTH(D), .CKPT_W(W)) bif ();
  branch_stack #(.DEPTH(D), .CKPT_W(W)) dut (.clock(clock), .reset(reset), .bus(bif));

  int checks   = 0;
  int failures = 0;

  // Model: live flag, allocation age, payload per id. A branch depends on x
  // exactly when both are live and it was allocated after x.
  bit              mv[D];
  int              ms[D];
  logic [W-1:0]    mc[D];
  int              seqc;
  int              m_x;
  bit              m_ok;
  logic            e_gnt, e_full, e_cv, e_sv;
  logic [D-1:0]    e_id, e_mask, e_cid, e_smask;
  logic [W-1:0]    e_sck;
  logic [31:0]     e_st;
  int              e_live;
  logic [W-1:0]    ck[D];

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin mv[i] = 0; ms[i] = 0; mc[i] = '0; end
    seqc = 0; e_cv = 0; e_sv = 0; e_cid = '0; e_smask = '0; e_sck = '0; e_st = '0;
    e_live = 0;
  endtask

  task automatic model_comb();
    m_x = -1;
    for (int i = 0; i < D; i++) if (bif.res_b_id[i]) m_x = i;
    m_ok   = bif.res_valid && (m_x >= 0) && mv[m_x];
    e_full = 1;
    for (int i = 0; i < D; i++) if (!mv[i]) e_full = 0;
    e_gnt = bif.alloc_req && !e_full && !(bif.res_valid && bif.res_task == SQ);
    e_id  = '0;
    if (e_gnt) begin
      for (int i = D - 1; i >= 0; i--) if (!mv[i]) e_id = D'(1) << i;
    end
    e_mask = '0;
    for (int i = 0; i < D; i++)
      if (mv[i] && !(m_ok && bif.res_task == CLR && i == m_x)) e_mask[i] = 1'b1;
  endtask

  task automatic model_edge();
    e_cv = 0; e_cid = '0; e_sv = 0; e_smask = '0; e_sck = '0; e_st = '0;
    if (m_ok && bif.res_task == CLR) begin
      e_cv = 1; e_cid = bif.res_b_id; mv[m_x] = 0;
    end else if (m_ok && bif.res_task == SQ) begin
      e_sv = 1; e_sck = mc[m_x]; e_st = bif.res_target;
      for (int j = 0; j < D; j++)
        if (mv[j] && (j == m_x || ms[j] > ms[m_x])) e_smask[j] = 1'b1;
      for (int j = 0; j < D; j++) if (e_smask[j]) mv[j] = 0;
    end
    if (e_gnt) begin
      for (int j = 0; j < D; j++)
        if (e_id[j]) begin mv[j] = 1; ms[j] = seqc; mc[j] = bif.alloc_ckpt; seqc++; end
    end
    e_live = 0;
    for (int j = 0; j < D; j++) e_live += int'(mv[j]);
  endtask

  task automatic drive(input logic req, input logic [W-1:0] c, input logic rv,
                       input logic [1:0] tk, input logic [D-1:0] bid, input logic [31:0] tgt);
    @(negedge clock);
    bif.alloc_req = req; bif.alloc_ckpt = c; bif.res_valid = rv;
    bif.res_task = tk; bif.res_b_id = bid; bif.res_target = tgt;
    model_comb();
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    bif.alloc_req = 0; bif.alloc_ckpt = '0; bif.res_valid = 0;
    bif.res_task = NOP; bif.res_b_id = '0; bif.res_target = '0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bif.alloc_req = 0; bif.alloc_ckpt = '0; bif.res_valid = 0;
    bif.res_task = NOP; bif.res_b_id = '0; bif.res_target = '0;
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (bif.live_cnt !== '0) begin failures++; $display("FAIL reset_live got=%0d exp=0", bif.live_cnt); end
    checks++; if (bif.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", bif.full); end
    checks++; if (bif.clear_valid !== 1'b0 || bif.clear_b_id !== '0) begin failures++; $display("FAIL reset_clear got=%0b/%0h exp=0/0", bif.clear_valid, bif.clear_b_id); end
    checks++; if (bif.squash_valid !== 1'b0 || bif.squash_b_mask !== '0 || bif.squash_ckpt !== '0 || bif.squash_target !== '0) begin failures++; $display("FAIL reset_squash got=%0b/%0h/%0h/%0h exp=0", bif.squash_valid, bif.squash_b_mask, bif.squash_ckpt, bif.squash_target); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_fill();
    logic [D-1:0] xid, xmask;
    for (int i = 0; i < D; i++) begin
      ck[i] = {$urandom, $urandom};
      xid   = D'(1) << i;
      xmask = xid - D'(1);
      drive(1, ck[i], 0, NOP, '0, '0);
      checks++; if (bif.alloc_gnt !== 1'b1) begin failures++; $display("FAIL fill_gnt%0d got=%0b exp=1", i, bif.alloc_gnt); end
      checks++; if (bif.alloc_b_id !== xid) begin failures++; $display("FAIL fill_id%0d got=%b exp=%b", i, bif.alloc_b_id, xid); end
      checks++; if (bif.alloc_b_mask !== xmask) begin failures++; $display("FAIL fill_mask%0d got=%b exp=%b", i, bif.alloc_b_mask, xmask); end
      tick();
      checks++; if (int'(bif.live_cnt) !== i + 1) begin failures++; $display("FAIL fill_live%0d got=%0d exp=%0d", i, bif.live_cnt, i + 1); end
    end
    drive(0, '0, 0, NOP, '0, '0);
    checks++; if (bif.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", bif.full); end
  endtask

  task automatic test_full();
    drive(1, {$urandom, $urandom}, 0, NOP, '0, '0);
    checks++; if (bif.alloc_gnt !== 1'b0 || bif.alloc_b_id !== '0) begin failures++; $display("FAIL full_gnt got=%0b/%b exp=0/0000", bif.alloc_gnt, bif.alloc_b_id); end
    tick();
    checks++; if (bif.live_cnt !== 3'd4) begin failures++; $display("FAIL full_live got=%0d exp=4", bif.live_cnt); end
  endtask

  task automatic test_clear();
    drive(0, '0, 1, CLR, 4'b0010, '0);
    tick();
    checks++; if (bif.clear_valid !== 1'b1 || bif.clear_b_id !== 4'b0010) begin failures++; $display("FAIL clear_pulse got=%0b/%b exp=1/0010", bif.clear_valid, bif.clear_b_id); end
    checks++; if (bif.squash_valid !== 1'b0) begin failures++; $display("FAIL clear_nosquash got=%0b exp=0", bif.squash_valid); end
    checks++; if (bif.live_cnt !== 3'd3) begin failures++; $display("FAIL clear_live got=%0d exp=3", bif.live_cnt); end
    // Reuse id1; it is now the youngest, so squashing it must spare id2/id3
    // (which would also die if they kept a stale bit 1).
    drive(1, {$urandom, $urandom}, 0, NOP, '0, '0);
    checks++; if (bif.alloc_b_id !== 4'b0010 || bif.alloc_b_mask !== 4'b1101) begin failures++; $display("FAIL clear_realloc got=%b/%b exp=0010/1101", bif.alloc_b_id, bif.alloc_b_mask); end
    tick();
    drive(0, '0, 1, SQ, 4'b0010, 32'h40);
    tick();
    checks++; if (bif.squash_b_mask !== 4'b0010) begin failures++; $display("FAIL clear_depstrip got=%b exp=0010", bif.squash_b_mask); end
  endtask

  task automatic test_squash();
    do_reset();
    for (int i = 0; i < D; i++) begin
      ck[i] = {$urandom, $urandom};
      drive(1, ck[i], 0, NOP, '0, '0);
      tick();
    end
    drive(0, '0, 1, SQ, 4'b0010, 32'h1000);
    tick();
    checks++; if (bif.squash_valid !== 1'b1 || bif.squash_b_mask !== 4'b1110) begin failures++; $display("FAIL squash_mask got=%0b/%b exp=1/1110", bif.squash_valid, bif.squash_b_mask); end
    checks++; if (bif.squash_ckpt !== ck[1]) begin failures++; $display("FAIL squash_ckpt got=%h exp=%h", bif.squash_ckpt, ck[1]); end
    checks++; if (bif.squash_target !== 32'h1000) begin failures++; $display("FAIL squash_target got=%h exp=00001000", bif.squash_target); end
    checks++; if (bif.live_cnt !== 3'd1 || bif.clear_valid !== 1'b0) begin failures++; $display("FAIL squash_live got=%0d/%0b exp=1/0", bif.live_cnt, bif.clear_valid); end
  endtask

  task automatic test_clear_realloc();
    drive(1, {$urandom, $urandom}, 1, CLR, 4'b0001, '0);
    checks++; if (bif.alloc_gnt !== 1'b1 || bif.alloc_b_id !== 4'b0010 || bif.alloc_b_mask !== 4'b0000) begin failures++; $display("FAIL realloc_same got=%0b/%b/%b exp=1/0010/0000", bif.alloc_gnt, bif.alloc_b_id, bif.alloc_b_mask); end
    tick();
    checks++; if (bif.clear_valid !== 1'b1 || bif.clear_b_id !== 4'b0001 || bif.live_cnt !== 3'd1) begin failures++; $display("FAIL realloc_clear got=%0b/%b/%0d exp=1/0001/1", bif.clear_valid, bif.clear_b_id, bif.live_cnt); end
    drive(1, {$urandom, $urandom}, 0, NOP, '0, '0);
    checks++; if (bif.alloc_b_id !== 4'b0001 || bif.alloc_b_mask !== 4'b0010) begin failures++; $display("FAIL realloc_next got=%b/%b exp=0001/0010", bif.alloc_b_id, bif.alloc_b_mask); end
    tick();
  endtask

  task automatic test_squash_block();
    // live: id1 (older), id0 (younger)
    drive(1, {$urandom, $urandom}, 1, SQ, 4'b0001, 32'h2222);
    checks++; if (bif.alloc_gnt !== 1'b0 || bif.alloc_b_id !== '0) begin failures++; $display("FAIL block_gnt got=%0b/%b exp=0/0000", bif.alloc_gnt, bif.alloc_b_id); end
    tick();
    checks++; if (bif.squash_valid !== 1'b1 || bif.squash_b_mask !== 4'b0001 || bif.live_cnt !== 3'd1) begin failures++; $display("FAIL block_squash got=%0b/%b/%0d exp=1/0001/1", bif.squash_valid, bif.squash_b_mask, bif.live_cnt); end
    drive(0, '0, 1, CLR, 4'b0100, '0);
    tick();
    checks++; if (bif.clear_valid !== 1'b0 || bif.squash_valid !== 1'b0 || bif.live_cnt !== 3'd1) begin failures++; $display("FAIL invalid_clear got=%0b/%0b/%0d exp=0/0/1", bif.clear_valid, bif.squash_valid, bif.live_cnt); end
    drive(1, '0, 1, SQ, 4'b1000, 32'h3);
    checks++; if (bif.alloc_gnt !== 1'b0) begin failures++; $display("FAIL invalid_sq_gnt got=%0b exp=0", bif.alloc_gnt); end
    tick();
    checks++; if (bif.squash_valid !== 1'b0 || bif.live_cnt !== 3'd1) begin failures++; $display("FAIL invalid_squash got=%0b/%0d exp=0/1", bif.squash_valid, bif.live_cnt); end
    drive(0, '0, 1, SQ, 4'b0010, 32'h2000);
    tick();
    checks++; if (bif.squash_valid !== 1'b1 || bif.squash_target !== 32'h2000) begin failures++; $display("FAIL midsq_pulse got=%0b/%h exp=1/00002000", bif.squash_valid, bif.squash_target); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++; if (bif.squash_valid !== 1'b0 || bif.squash_b_mask !== '0 || bif.squash_ckpt !== '0 || bif.squash_target !== '0 || bif.clear_valid !== 1'b0 || bif.live_cnt !== '0) begin failures++; $display("FAIL midsq_reset got=%0b/%b/%h/%h/%0b/%0d exp=all 0", bif.squash_valid, bif.squash_b_mask, bif.squash_ckpt, bif.squash_target, bif.clear_valid, bif.live_cnt); end
    @(negedge clock);
    bif.res_valid = 0; bif.alloc_req = 0;
    reset = 1'b1;
  endtask

  task automatic test_random();
    int pick;
    logic [D-1:0] bid;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      pick = $urandom_range(0, D - 1);
      bid  = D'(1) << pick;
      if (!mv[pick] && $urandom_range(0, 3) != 0) begin
        for (int k = 0; k < D; k++) if (mv[(pick + k) % D]) bid = D'(1) << ((pick + k) % D);
      end
      if ($urandom_range(0, 19) == 0) bid = '0;
      drive($urandom_range(0, 2) != 0, {$urandom, $urandom}, $urandom_range(0, 9) < 5,
            2'($urandom_range(0, 2)), bid, $urandom);
      checks++; if (bif.alloc_gnt !== e_gnt || bif.alloc_b_id !== e_id) begin failures++; $display("FAIL rnd_alloc@%0d got=%0b/%b exp=%0b/%b", n, bif.alloc_gnt, bif.alloc_b_id, e_gnt, e_id); end
      checks++; if (bif.alloc_b_mask !== e_mask || bif.full !== e_full) begin failures++; $display("FAIL rnd_mask@%0d got=%b/%0b exp=%b/%0b", n, bif.alloc_b_mask, bif.full, e_mask, e_full); end
      tick();
      checks++; if (bif.clear_valid !== e_cv || (e_cv && bif.clear_b_id !== e_cid)) begin failures++; $display("FAIL rnd_clear@%0d got=%0b/%b exp=%0b/%b", n, bif.clear_valid, bif.clear_b_id, e_cv, e_cid); end
      checks++; if (bif.squash_valid !== e_sv || (e_sv && (bif.squash_b_mask !== e_smask || bif.squash_ckpt !== e_sck || bif.squash_target !== e_st))) begin failures++; $display("FAIL rnd_squash@%0d got=%0b/%b/%h/%h exp=%0b/%b/%h/%h", n, bif.squash_valid, bif.squash_b_mask, bif.squash_ckpt, bif.squash_target, e_sv, e_smask, e_sck, e_st); end
      checks++; if (int'(bif.live_cnt) !== e_live) begin failures++; $display("FAIL rnd_live@%0d got=%0d exp=%0d", n, bif.live_cnt, e_live); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full();
    test_clear();
    test_squash();
    test_clear_realloc();
    test_squash_block();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
